// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and state encoding for the 7-segment scan controller.
package seg_scan_ctrl_pkg;

    localparam logic [7:0] SEG_BLANK   = 8'h00;
    localparam logic [7:0] SEG_INVALID = 8'h3f;
    localparam int         DP_BIT      = 7;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle: load path from the status logic and scan outputs to the LED pins.
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 4
) ();
    logic [4*DIGITS-1:0] Value;
    logic [DIGITS-1:0]   Point;
    logic                Load;
    logic                Lzb;
    logic                Pending;
    logic                FrameDone;
    logic [DIGITS-1:0]   DigSel;
    logic [7:0]          LedBit;

    modport slave (
        input  Value, Point, Load, Lzb,
        output Pending, FrameDone, DigSel, LedBit
    );

    modport master (
        output Value, Point, Load, Lzb,
        input  Pending, FrameDone, DigSel, LedBit
    );
endinterface

// File: rtl/seg_scan_ctrl_bcd2led.sv
// BCD digit to segment pattern (bit7 = dp, bits6:0 = g..a); non-BCD codes show "0".
module seg_scan_ctrl_bcd2led
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       point_i,
    output logic [7:0] led_bit_o
);

    logic [7:0] seg_s;

    // Segment lookup with the dp bit merged on top
    always_comb begin
        seg_s = SEG_INVALID;
        case (bcd_i)
            4'd0:    seg_s = 8'h3f;
            4'd1:    seg_s = 8'h06;
            4'd2:    seg_s = 8'h5b;
            4'd3:    seg_s = 8'h4f;
            4'd4:    seg_s = 8'h66;
            4'd5:    seg_s = 8'h6d;
            4'd6:    seg_s = 8'h7d;
            4'd7:    seg_s = 8'h07;
            4'd8:    seg_s = 8'h7f;
            4'd9:    seg_s = 8'h6f;
            default: seg_s = SEG_INVALID;
        endcase
        led_bit_o         = seg_s;
        led_bit_o[DP_BIT] = seg_s[DP_BIT] | point_i;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered value, blanking gap
// between digits and leading-zero blanking.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_ctrl_if.slave bus
);

    localparam int PH_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SCAN_DIV - 1);
    localparam logic [PH_W-1:0]  PH_BLANK = PH_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [PH_W-1:0]     phase_q, phase_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    scan_state_e         state_q, state_d;
    logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0]   shadow_pt_q, shadow_pt_d;
    logic [4*DIGITS-1:0] active_val_q, active_val_d;
    logic [DIGITS-1:0]   active_pt_q, active_pt_d;
    logic                pending_q, pending_d;
    logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;
    logic [7:0]          led_bit_q, led_bit_d;
    logic                frame_done_q, frame_done_d;

    logic                boundary_s;
    logic [DIGITS-1:0]   blank_s;
    logic                zero_run_s;
    logic [3:0]          cur_digit_s;
    logic                cur_pt_s;
    logic                cur_blank_s;
    logic [7:0]          dec_s;

    // Scan position advance and shadow/active buffer management
    always_comb begin
        phase_d      = phase_q;
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_pt_d  = shadow_pt_q;
        active_val_d = active_val_q;
        active_pt_d  = active_pt_q;
        pending_d    = pending_q;
        boundary_s   = (phase_q == PH_LAST) && (idx_q == IDX_LAST);

        if (phase_q == PH_LAST) begin
            phase_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            phase_d = phase_q + 1'b1;
        end

        // Transfer uses the shadow as it stood before this cycle's Load
        if (boundary_s && pending_q) begin
            active_val_d = shadow_val_q;
            active_pt_d  = shadow_pt_q;
            pending_d    = 1'b0;
        end else begin
            active_val_d = active_val_q;
            active_pt_d  = active_pt_q;
        end

        if (bus.Load) begin
            shadow_val_d = bus.Value;
            shadow_pt_d  = bus.Point;
            pending_d    = 1'b1;
        end else begin
            shadow_val_d = shadow_val_q;
            shadow_pt_d  = shadow_pt_q;
        end
    end

    // BLANK/SHOW next-state from the upcoming phase
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BLANK: begin
                if (phase_d >= PH_BLANK) begin
                    state_d = ST_SHOW;
                end else begin
                    state_d = ST_BLANK;
                end
            end
            ST_SHOW: begin
                if (phase_d < PH_BLANK) begin
                    state_d = ST_BLANK;
                end else begin
                    state_d = ST_SHOW;
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // Leading-zero mask: a zero run from the top, broken by a non-zero digit or a lit point
    always_comb begin
        blank_s    = '0;
        zero_run_s = bus.Lzb;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run_s = zero_run_s & (active_val_d[4*i +: 4] == 4'd0) & ~active_pt_d[i];
            blank_s[i] = zero_run_s;
        end
    end

    assign cur_digit_s = active_val_d[{idx_d, 2'b00} +: 4];
    assign cur_pt_s    = active_pt_d[idx_d];
    assign cur_blank_s = blank_s[idx_d];

    seg_scan_ctrl_bcd2led u_bcd_to_ledbit (
        .bcd_i     (cur_digit_s),
        .point_i   (1'b0),
        .led_bit_o (dec_s)
    );

    // Output values for the upcoming cycle, registered below
    always_comb begin
        dig_sel_d    = '1;
        led_bit_d    = SEG_BLANK;
        frame_done_d = (phase_d == PH_LAST) && (idx_d == IDX_LAST);
        case (state_d)
            ST_BLANK: begin
                dig_sel_d = '1;
                led_bit_d = SEG_BLANK;
            end
            ST_SHOW: begin
                dig_sel_d = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_d);
                if (cur_blank_s) begin
                    led_bit_d = SEG_BLANK;
                end else begin
                    led_bit_d         = dec_s;
                    led_bit_d[DP_BIT] = dec_s[DP_BIT] | cur_pt_s;
                end
            end
            default: begin
                dig_sel_d = '1;
                led_bit_d = SEG_BLANK;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= '0;
            idx_q        <= '0;
            state_q      <= (BLANK_CYC > 0) ? ST_BLANK : ST_SHOW;
            shadow_val_q <= '0;
            shadow_pt_q  <= '0;
            active_val_q <= '0;
            active_pt_q  <= '0;
            pending_q    <= 1'b0;
            dig_sel_q    <= '1;
            led_bit_q    <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            shadow_val_q <= shadow_val_d;
            shadow_pt_q  <= shadow_pt_d;
            active_val_q <= active_val_d;
            active_pt_q  <= active_pt_d;
            pending_q    <= pending_d;
            dig_sel_q    <= dig_sel_d;
            led_bit_q    <= led_bit_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.Pending   = pending_q;
    assign bus.FrameDone = frame_done_q;
    assign bus.DigSel    = dig_sel_q;
    assign bus.LedBit    = led_bit_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
module tb_seg_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = DIGITS * SCAN_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_chk  = 0;
    int   pos    = 0;
    int   fd_cnt = 0;

    seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_ctrl #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pos = (pos + 1) % FRAME;
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (pos != target && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        if (pos != target) chk("run_to_timeout", 16'(pos), 16'(target));
    endtask

    task automatic load(input logic [15:0] val, input logic [3:0] pt);
        bus.Value = val;
        bus.Point = pt;
        bus.Load  = 1'b1;
        tick();
        bus.Load  = 1'b0;
    endtask

    // Check a digit's SHOW slot at its first and last SHOW phase
    task automatic check_show(input string tag, input int idx, input logic [7:0] led);
        logic [3:0] sel;
        sel = ~(4'b0001 << idx);
        run_to(idx * SCAN_DIV + BLANK_CYC);
        chk({tag, "_sel"}, 16'(bus.DigSel), 16'(sel));
        chk({tag, "_led"}, 16'(bus.LedBit), 16'(led));
        run_to(idx * SCAN_DIV + SCAN_DIV - 1);
        chk({tag, "_led_end"}, 16'(bus.LedBit), 16'(led));
    endtask

    initial begin
        bus.Value = 16'h0000;
        bus.Point = 4'b0000;
        bus.Load  = 1'b0;
        bus.Lzb   = 1'b0;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        pos = 0;
        chk("rst_sel", 16'(bus.DigSel), 16'h000f);
        chk("rst_led", 16'(bus.LedBit), 16'h0000);
        chk("rst_pend", 16'(bus.Pending), 16'h0000);
        chk("rst_fd", 16'(bus.FrameDone), 16'h0000);

        // First slot: two blank phases, then digit 0 showing "0"
        for (int p = 0; p < SCAN_DIV; p++) begin
            if (p > 0) tick();
            chk("slot0_sel", 16'(bus.DigSel), (p < BLANK_CYC) ? 16'h000f : 16'h000e);
            chk("slot0_led", 16'(bus.LedBit), (p < BLANK_CYC) ? 16'h0000 : 16'h003f);
        end

        fd_cnt = 0;
        for (int c = 0; c < FRAME; c++) begin
            tick();
            if (bus.FrameDone === 1'b1) fd_cnt++;
        end
        chk("fd_per_frame", 16'(fd_cnt), 16'd1);

        // Mid-frame load becomes visible only after the boundary
        run_to(13);
        load(16'h1234, 4'b0000);
        chk("ld_pend_rise", 16'(bus.Pending), 16'h0001);
        run_to(18);
        chk("ld_unchanged", 16'(bus.LedBit), 16'h003f);
        run_to(31);
        chk("ld_fd", 16'(bus.FrameDone), 16'h0001);
        chk("ld_pend_held", 16'(bus.Pending), 16'h0001);
        tick();
        chk("ld_pend_clr", 16'(bus.Pending), 16'h0000);
        chk("ld_fd_low", 16'(bus.FrameDone), 16'h0000);
        check_show("v1234_d0", 0, 8'h66);
        check_show("v1234_d1", 1, 8'h4f);
        check_show("v1234_d2", 2, 8'h5b);
        check_show("v1234_d3", 3, 8'h06);
        tick();

        // Leading-zero blanking with and without a decimal point breaking the run
        bus.Lzb = 1'b1;
        load(16'h0007, 4'b0000);
        run_to(0);
        check_show("lzb_d0", 0, 8'h07);
        check_show("lzb_d1", 1, 8'h00);
        check_show("lzb_d2", 2, 8'h00);
        check_show("lzb_d3", 3, 8'h00);
        tick();
        load(16'h0007, 4'b0100);
        run_to(0);
        check_show("lzbdp_d0", 0, 8'h07);
        check_show("lzbdp_d1", 1, 8'h3f);
        check_show("lzbdp_d2", 2, 8'hbf);
        check_show("lzbdp_d3", 3, 8'h00);
        tick();

        // Non-BCD codes decode as "0"
        bus.Lzb = 1'b0;
        load(16'hfa90, 4'b0000);
        run_to(0);
        check_show("fa90_d0", 0, 8'h3f);
        check_show("fa90_d1", 1, 8'h6f);
        check_show("fa90_d2", 2, 8'h3f);
        check_show("fa90_d3", 3, 8'h3f);
        tick();

        // Load on the boundary cycle: old shadow transfers, new one stays pending
        load(16'h1111, 4'b0000);
        run_to(31);
        chk("bnd_fd", 16'(bus.FrameDone), 16'h0001);
        chk("bnd_pend_pre", 16'(bus.Pending), 16'h0001);
        load(16'h2222, 4'b0000);
        chk("bnd_pend_post", 16'(bus.Pending), 16'h0001);
        check_show("v1111_d0", 0, 8'h06);
        check_show("v1111_d1", 1, 8'h06);
        check_show("v1111_d2", 2, 8'h06);
        check_show("v1111_d3", 3, 8'h06);
        chk("bnd_pend_frame", 16'(bus.Pending), 16'h0001);
        tick();
        chk("bnd_pend_clr", 16'(bus.Pending), 16'h0000);
        check_show("v2222_d0", 0, 8'h5b);
        check_show("v2222_d1", 1, 8'h5b);
        check_show("v2222_d2", 2, 8'h5b);
        check_show("v2222_d3", 3, 8'h5b);
        tick();

        // Reset mid-SHOW with a load still pending
        load(16'h5555, 4'b0000);
        run_to(0);
        run_to(2 * SCAN_DIV + 3);
        chk("pre_rst_sel", 16'(bus.DigSel), 16'h000b);
        chk("pre_rst_led", 16'(bus.LedBit), 16'h006d);
        load(16'h9999, 4'b0000);
        chk("pre_rst_pend", 16'(bus.Pending), 16'h0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pos = 0;
        chk("mid_rst_sel", 16'(bus.DigSel), 16'h000f);
        chk("mid_rst_led", 16'(bus.LedBit), 16'h0000);
        chk("mid_rst_pend", 16'(bus.Pending), 16'h0000);
        chk("mid_rst_fd", 16'(bus.FrameDone), 16'h0000);
        check_show("post_rst_d0", 0, 8'h3f);
        check_show("post_rst_d1", 1, 8'h3f);
        check_show("post_rst_d2", 2, 8'h3f);
        check_show("post_rst_d3", 3, 8'h3f);
        tick();
        check_show("post_rst_next_d0", 0, 8'h3f);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a DIGITS-wide common-anode/cathode 7-segment display bank. It holds a double-buffered BCD display value and walks a one-hot digit select through the digits at a programmable slot rate. It inserts a blanking gap between digits to suppress ghosting and drives the shared segment bus through the team's BCD-to-segment decoder. It sits between the measurement/status logic (frame counters, register readback) and the board's LED pins.

## Interface
- DIGITS, 4: number of digits; index 0 = least significant, Value[3:0].
- SCAN_DIV, 50000: clocks per digit slot; ≥ 2.
- BLANK_CYC, 16: blank clocks at start of each slot; 0 ≤ BLANK_CYC < SCAN_DIV.
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- Value  in  4*DIGITS  BCD digits to display, sampled on Load.
- Point  in  DIGITS  decimal-point mask, sampled on Load.
- Load  in  1  one-cycle strobe, captures Value/Point into shadow.
- Lzb  in  1  leading-zero blanking enable (live, not latched).
- Pending  out  1  shadow holds data not yet shown.
- FrameDone  out  1  one-cycle pulse on last cycle of each frame.
- DigSel  out  DIGITS  active-low one-hot digit enable.
- LedBit  out  8  segments, active-high, bit7 = dp, bits6:0 = g..a.

## Operation
- Registers: phase counter 0..SCAN_DIV-1, digit index 0..DIGITS-1, shadow Value/Point, active Value/Point, Pending.
- State machine: BLANK (phase < BLANK_CYC), SHOW (phase ≥ BLANK_CYC).
  - BLANK: DigSel all ones, LedBit 8'h00.
  - SHOW: DigSel[index]=0, others 1; LedBit = decode(active digit[index]) | (Point[index]<<7).
  - BLANK_CYC=0: SHOW for whole slot.
- Phase wraps at SCAN_DIV-1; index increments on wrap, wraps DIGITS-1 → 0. Frame = DIGITS slots.
- Decode: 0..9 → 3f,06,5b,4f,66,6d,7d,07,7f,6f; codes 10–15 → 8'h3f.
- Leading-zero blanking (Lzb=1): scan from index DIGITS-1 downward. A digit is blanked while it and all higher digits are 0 and its Point bit is clear. Digit 0 is never blanked. A blanked digit in SHOW keeps its DigSel asserted with LedBit 8'h00.
- Load: shadow ← Value/Point, Pending ← 1. Load while Pending overwrites shadow (last wins).
- Frame boundary (phase=SCAN_DIV-1, index=DIGITS-1): FrameDone=1. If Pending was set before this cycle, active ← shadow and Pending ← 0.
- Load on boundary cycle: transfer uses the pre-existing shadow (if Pending). The new Load lands in shadow and Pending = 1 after the cycle. It is shown at the next boundary.
- Reset at any point, including mid-SHOW: next cycle phase=0, index=0, state BLANK, shadow/active=0, Pending=0.

## Timing
- All outputs are registered; each cycle they reflect the current phase/index (next-state precomputed). No combinational input→output path.
- Reset values: DigSel all ones, LedBit 8'h00, Pending 0, FrameDone 0.
- First cycle after rst deasserts: phase 0, index 0.
- Pending rises the cycle after Load.
- New active value is visible from phase 0 of index 0 of the next frame. Worst-case Load→display = DIGITS*SCAN_DIV+1 clocks.
- FrameDone is high exactly 1 cycle per DIGITS*SCAN_DIV clocks.

## Structure
- Shared package/header: segment constants (SEG_BLANK 8'h00, DP bit index 7), BLANK/SHOW state encoding.
- One sub-module: BCD_to_LedBit, single instance on the muxed active digit. Its Point input is tied 0; dp is ORed in by this block.
- Blanking-mask generation is local combinational logic on the active register.

## Test plan
Parameters: DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
- Reset, then run 8 clocks → phases 0–1: DigSel 4'b1111, LedBit 00; phases 2–7: DigSel 4'b1110, LedBit 3f. FrameDone pulses once every 32 clocks.
- Load Value 16'h1234 mid-frame → Pending=1 next cycle, display unchanged until FrameDone, Pending=0 after it. Next frame SHOW outputs: idx0 66, idx1 4f, idx2 5b, idx3 06.
- Lzb=1, Value 16'h0007, Point 0 → idx3/2/1 SHOW: LedBit 00 with DigSel asserted; idx0 07. Then Point 4'b0100 → idx2 bf, idx1 3f, idx3 00.
- Value 16'hFA90, Lzb=0 → idx0 3f, idx1 6f, idx2 3f, idx3 3f.
- Load 16'h1111 then Load 16'h2222 on the boundary cycle → next frame shows 1111 (06 each), Pending stays 1, following frame shows 2222 (5b).
- Assert rst for 1 cycle during idx2 SHOW with active 16'h5555 → next cycle DigSel 1111, LedBit 00, Pending 0. Subsequent frame shows 3f on all digits.
